// File: rtl/bisect_scheduler.sv
// ============================================================================
//  Module  : bisect_scheduler
//  Brief   : Depth-first triangle subdivision controller with an on-chip LIFO
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bisect_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t     p;
    vertex_t     q;
    vertex_t     r;
    logic [23:0] colour;
  } Triangle3D;
endpackage

module bisect_scheduler
  import bisect_pkg::*;
#(
  parameter logic [15:0] MAX_EDGE    = 16'd8,
  parameter int          MAX_DEPTH   = 4,
  parameter int          STACK_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  Triangle3D in_tri,
  output logic      in_ready,
  output logic      bis_valid,
  output Triangle3D bis_tri,
  input  logic      bis_done,
  input  Triangle3D bis_tri_a,
  input  Triangle3D bis_tri_b,
  output logic      out_valid,
  output Triangle3D out_tri,
  output logic      out_last,
  input  logic      out_ready,
  output logic      busy
);

  localparam int DW  = (MAX_DEPTH > 0) ? $clog2(MAX_DEPTH + 1) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  if (STACK_DEPTH < MAX_DEPTH + 1) begin : g_param_check
    $error("bisect_scheduler: STACK_DEPTH must be at least MAX_DEPTH+1");
  end

  typedef struct packed {
    Triangle3D       tri3d;
    logic [DW-1:0]   depth;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EVAL, BISECT, EMIT} state_t;

  state_t         state;
  entry_t         stack [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;
  entry_t         top;

  assign top_idx  = IW'(sp - SPW'(1));
  assign push_idx = IW'(sp);
  assign top      = stack[top_idx];
  assign busy     = (state != IDLE) || (sp != '0);

  // Chebyshev length of one axis of an edge, compared against MAX_EDGE.
  function automatic logic axis_ok(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [16:0] d;
    logic        [16:0] m;
    d = {a[15], a} - {b[15], b};
    m = d[16] ? (~d + 17'd1) : d;
    return m <= {1'b0, MAX_EDGE};
  endfunction

  function automatic logic edge_ok(input Triangle3D t);
    return axis_ok(t.p.x, t.q.x) && axis_ok(t.p.y, t.q.y) &&
           axis_ok(t.q.x, t.r.x) && axis_ok(t.q.y, t.r.y) &&
           axis_ok(t.r.x, t.p.x) && axis_ok(t.r.y, t.p.y);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= '0;
      in_ready  <= 1'b1;
      bis_valid <= 1'b0;
      bis_tri   <= '0;
      out_valid <= 1'b0;
      out_tri   <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            stack[push_idx] <= entry_t'{tri3d: in_tri, depth: '0};
            sp              <= sp + SPW'(1);
            in_ready        <= 1'b0;
            state           <= EVAL;
          end
        end
        EVAL: begin
          if (edge_ok(top.tri3d) || (top.depth == DW'(MAX_DEPTH))) begin
            out_valid <= 1'b1;
            out_tri   <= top.tri3d;
            out_last  <= (sp == SPW'(1));
            state     <= EMIT;
          end else begin
            bis_valid <= 1'b1;
            bis_tri   <= top.tri3d;
            state     <= BISECT;
          end
        end
        BISECT: begin
          // Half B replaces the parent, half A lands on top and is processed first.
          if (bis_done) begin
            stack[top_idx]  <= entry_t'{tri3d: bis_tri_b, depth: top.depth + DW'(1)};
            stack[push_idx] <= entry_t'{tri3d: bis_tri_a, depth: top.depth + DW'(1)};
            sp              <= sp + SPW'(1);
            bis_valid       <= 1'b0;
            state           <= EVAL;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sp        <= sp - SPW'(1);
            if (sp == SPW'(1)) begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state    <= EVAL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bisect_scheduler.sv
// ============================================================================
//  Module  : tb_bisect_scheduler
//  Brief   : Table-driven scoreboard bench for bisect_scheduler
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bisect_scheduler;
  import bisect_pkg::*;

  localparam int EDGE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic      sel;
  logic      in_valid;
  Triangle3D in_tri;
  logic      bis_done;
  Triangle3D bis_a, bis_b;
  logic      out_ready;

  logic      in_valid1, in_ready1, bis_valid1, out_valid1, out_last1, busy1;
  logic      in_valid2, in_ready2, bis_valid2, out_valid2, out_last2, busy2;
  Triangle3D bis_tri1, out_tri1, bis_tri2, out_tri2;

  assign in_valid1 = in_valid && !sel;
  assign in_valid2 = in_valid && sel;

  logic      cur_in_ready, cur_bis_valid, cur_out_valid, cur_out_last, cur_busy;
  Triangle3D cur_bis_tri, cur_out_tri;
  assign cur_in_ready  = sel ? in_ready2  : in_ready1;
  assign cur_bis_valid = sel ? bis_valid2 : bis_valid1;
  assign cur_out_valid = sel ? out_valid2 : out_valid1;
  assign cur_out_last  = sel ? out_last2  : out_last1;
  assign cur_busy      = sel ? busy2      : busy1;
  assign cur_bis_tri   = sel ? bis_tri2   : bis_tri1;
  assign cur_out_tri   = sel ? out_tri2   : out_tri1;

  bisect_scheduler #(.MAX_EDGE(16'd8), .MAX_DEPTH(1), .STACK_DEPTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_tri(in_tri), .in_ready(in_ready1),
    .bis_valid(bis_valid1), .bis_tri(bis_tri1), .bis_done(bis_done),
    .bis_tri_a(bis_a), .bis_tri_b(bis_b), .out_valid(out_valid1), .out_tri(out_tri1),
    .out_last(out_last1), .out_ready(out_ready), .busy(busy1));

  bisect_scheduler #(.MAX_EDGE(16'd8), .MAX_DEPTH(2), .STACK_DEPTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_tri(in_tri), .in_ready(in_ready2),
    .bis_valid(bis_valid2), .bis_tri(bis_tri2), .bis_done(bis_done),
    .bis_tri_a(bis_a), .bis_tri_b(bis_b), .out_valid(out_valid2), .out_tri(out_tri2),
    .out_last(out_last2), .out_ready(out_ready), .busy(busy2));

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int peak  = 0;
  int bis_delay = 0;
  int bis_wait  = 0;

  typedef struct { Triangle3D t; logic last; } leaf_t;
  leaf_t sb[$];

  typedef struct { Triangle3D t; logic sel; int exp_count; int exp_peak; int delay; } vec_t;

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic Triangle3D mk(input int px, input int py, input int qx, input int qy,
                                   input int rx, input int ry);
    Triangle3D t;
    t.p = '{x: 16'(px), y: 16'(py), z: 16'd1};
    t.q = '{x: 16'(qx), y: 16'(qy), z: 16'd2};
    t.r = '{x: 16'(rx), y: 16'(ry), z: 16'd3};
    t.colour = 24'hC0FFEE;
    return t;
  endfunction

  function automatic int cheb(input vertex_t a, input vertex_t b);
    int dx, dy;
    dx = int'(a.x) - int'(b.x);
    dy = int'(a.y) - int'(b.y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx > dy) ? dx : dy;
  endfunction

  function automatic logic is_leaf(input Triangle3D t);
    return cheb(t.p, t.q) <= EDGE_LIMIT && cheb(t.q, t.r) <= EDGE_LIMIT &&
           cheb(t.r, t.p) <= EDGE_LIMIT;
  endfunction

  function automatic vertex_t mid(input vertex_t a, input vertex_t b);
    vertex_t m;
    m.x = 16'((int'(a.x) + int'(b.x)) >>> 1);
    m.y = 16'((int'(a.y) + int'(b.y)) >>> 1);
    m.z = a.z;
    return m;
  endfunction

  // Reference bisect unit: split the longest edge at its midpoint.
  function automatic void split(input Triangle3D t, output Triangle3D a, output Triangle3D b);
    int l0, l1, l2;
    l0 = cheb(t.p, t.q); l1 = cheb(t.q, t.r); l2 = cheb(t.r, t.p);
    a = t; b = t;
    if (l0 >= l1 && l0 >= l2) begin
      a.q = mid(t.p, t.q); b.p = a.q;
    end else if (l1 >= l2) begin
      a.r = mid(t.q, t.r); b.q = a.r;
    end else begin
      a.r = mid(t.r, t.p); b.p = a.r;
    end
  endfunction

  // Expand the leaf list in place until stable; in-place expansion gives depth-first order.
  function automatic void gen(input Triangle3D t, input int maxd);
    Triangle3D lst[$], nl[$];
    int        dep[$], nd[$];
    Triangle3D a, b;
    bit        changed;
    lst.push_back(t); dep.push_back(0);
    changed = 1'b1;
    while (changed) begin
      changed = 1'b0;
      nl.delete(); nd.delete();
      foreach (lst[i]) begin
        if (!is_leaf(lst[i]) && dep[i] < maxd) begin
          split(lst[i], a, b);
          nl.push_back(a); nd.push_back(dep[i] + 1);
          nl.push_back(b); nd.push_back(dep[i] + 1);
          changed = 1'b1;
        end else begin
          nl.push_back(lst[i]); nd.push_back(dep[i]);
        end
      end
      lst = nl; dep = nd;
    end
    foreach (lst[i]) sb.push_back('{t: lst[i], last: (i == lst.size() - 1)});
  endfunction

  Triangle3D ta, tb_h;
  initial begin
    bis_done = 1'b0; bis_a = '0; bis_b = '0;
    forever begin
      @(negedge clk);
      if (cur_bis_valid && !bis_done) begin
        if (bis_wait < bis_delay) bis_wait++;
        else begin
          split(cur_bis_tri, ta, tb_h);
          bis_a = ta; bis_b = tb_h; bis_done = 1'b1;
        end
      end else begin
        bis_done = 1'b0; bis_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cur_out_valid && out_ready) begin
      leaf_t e;
      if (sb.size() == 0) check("unexpected leaf", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        check("leaf tri", cur_out_tri, e.t);
        check("leaf last", cur_out_last, e.last);
      end
      n_out++;
    end
    if (int'(u_dut2.sp) > peak) peak = int'(u_dut2.sp);
  end

  task automatic send(input Triangle3D t, input int maxd);
    @(posedge clk); #1;
    gen(t, maxd);
    in_valid = 1'b1; in_tri = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 2000 && (sb.size() != 0 || cur_busy); k++) @(negedge clk);
    check(name, (sb.size() == 0) && !cur_busy, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    sel = v.sel; bis_delay = v.delay; n_out = 0;
    @(negedge clk);
    peak = 0;
    send(v.t, v.sel ? 2 : 1);
    @(negedge clk);
    check("in_ready low while busy", cur_in_ready, 1'b0);
    if (v.exp_count == 1) begin
      check("no output in eval cycle", cur_out_valid, 1'b0);
      @(negedge clk);
      check("leaf latency", cur_out_valid, 1'b1);
    end
    wait_done("run completes");
    check("leaf count", n_out, v.exp_count);
    if (v.exp_peak != 0) check("peak stack", peak, v.exp_peak);
    check("in_ready after run", cur_in_ready, 1'b1);
  endtask

  vec_t      vecs[7];
  Triangle3D t2, a_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_tri = '0; out_ready = 1'b1;
    vecs[0] = '{mk(0, 0, 4, 0, 0, 4),               1'b0, 1, 0, 0};
    vecs[1] = '{mk(0, 0, 16, 0, 0, 4),              1'b0, 2, 0, 2};
    vecs[2] = '{mk(0, 0, 1000, 0, 0, 1000),         1'b1, 4, 3, 1};
    vecs[3] = '{mk(300, -300, 300, -300, 300, -300), 1'b1, 1, 0, 0};
    vecs[4] = '{mk(-4, -4, 4, 4, -4, 4),            1'b0, 1, 0, 0};
    vecs[5] = '{mk(-4, -4, 5, 4, -4, 4),            1'b0, 2, 0, 0};
    vecs[6] = '{mk(-32768, -32768, 32767, 32767, -32768, 32767), 1'b1, 4, 3, 0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      check("rst in_ready",  cur_in_ready,  1'b1);
      check("rst bis_valid", cur_bis_valid, 1'b0);
      check("rst out_valid", cur_out_valid, 1'b0);
      check("rst out_last",  cur_out_last,  1'b0);
      check("rst busy",      cur_busy,      1'b0);
      check("rst bis_tri",   cur_bis_tri,   '0);
      check("rst out_tri",   cur_out_tri,   '0);
    end
    sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure on the first leaf of a single split
    t2 = mk(0, 0, 16, 0, 0, 4);
    a_exp = mk(0, 0, 8, 0, 0, 4);
    a_exp.q.z = 16'd1;
    sel = 1'b0; bis_delay = 0; n_out = 0; out_ready = 1'b0;
    send(t2, 1);
    for (int k = 0; k < 100 && !cur_out_valid; k++) @(negedge clk);
    check("bp out_valid seen", cur_out_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp out_valid held", cur_out_valid, 1'b1);
      check("bp out_tri stable", cur_out_tri, a_exp);
      check("bp busy", cur_busy, 1'b1);
      check("bp no pop", u_dut1.sp, 2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("bp completes");
    check("bp leaf count", n_out, 2);

    // Bisect unit stalls for 7 cycles
    bis_delay = 7; n_out = 0;
    send(t2, 1);
    for (int k = 0; k < 100 && !cur_bis_valid; k++) @(negedge clk);
    check("stall bis_valid seen", cur_bis_valid, 1'b1);
    repeat (7) begin
      @(negedge clk);
      check("stall bis_valid held", cur_bis_valid, 1'b1);
      check("stall bis_tri stable", cur_bis_tri, t2);
      check("stall stack unchanged", u_dut1.sp, 1);
    end
    wait_done("stall completes");
    check("stall leaf count", n_out, 2);

    // Reset in the middle of a bisect
    sel = 1'b1; bis_delay = 3;
    send(mk(0, 0, 1000, 0, 0, 1000), 2);
    for (int k = 0; k < 100 && !cur_bis_valid; k++) @(negedge clk);
    check("mid bis_valid seen", cur_bis_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid rst out_valid", cur_out_valid, 1'b0);
    check("mid rst bis_valid", cur_bis_valid, 1'b0);
    check("mid rst busy", cur_busy, 1'b0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    run_vec('{mk(0, 0, 4, 0, 0, 4), 1'b1, 1, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
